// File: rtl/add_sub_seq.sv
// add_sub_seq: chunk-serial adder/subtractor, CHUNK bits per clock,
// start/busy/done framing with carry, overflow and zero flags.
module add_sub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_res;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic [CHUNK:0]   w_sum;
  logic             w_accept;
  logic             w_last;
  logic             w_ovf;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_idx == IW'(NCHUNK - 1));

  assign w_sa  = r_a[r_idx*CHUNK +: CHUNK];
  assign w_sb  = r_b[r_idx*CHUNK +: CHUNK];
  assign w_sum = {1'b0, w_sa} + {1'b0, w_sb}
               + {{CHUNK{1'b0}}, r_carry};

  always_comb begin
    w_res = r_work;
    w_res[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
  end

  // carry into the MSB is recovered as a^b^s at that bit
  assign w_ovf = r_a[WIDTH-1] ^ r_b[WIDTH-1]
               ^ w_res[WIDTH-1] ^ w_sum[CHUNK];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_work  <= w_res;
      r_carry <= w_sum[CHUNK];
      if (w_last) begin
        r_idx <= '0;
        s     <= w_res;
        cout  <= w_sum[CHUNK];
        ovf   <= w_ovf;
        zero  <= (w_res == '0);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_seq.sv
// Scoreboard bench for add_sub_seq: directed 8/4 vectors, handshake
// and reset cases, then a reference-model sweep on 8/1, 8/8, 32/8.
module tb_add_sub_seq;

  typedef struct {
    int          id;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  int          sel;

  logic [3:0]  st_v;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  cout_v;
  logic [3:0]  ovf_v;
  logic [3:0]  zero_v;
  logic [7:0]  s0;
  logic [7:0]  s1;
  logic [7:0]  s2;
  logic [31:0] s3;
  logic [31:0] s_v [4];

  exp_t sbq[$];
  int   nvec;
  int   nfail;
  int   cyc;
  int   busyc [4];

  assign st_v = start ? (4'b0001 << sel) : 4'b0000;
  assign s_v[0] = {24'b0, s0};
  assign s_v[1] = {24'b0, s1};
  assign s_v[2] = {24'b0, s2};
  assign s_v[3] = s3;

  add_sub_seq #(.WIDTH(8), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .start(st_v[0]), .sub(sub),
    .a(a[7:0]), .b(b[7:0]), .busy(busy_v[0]), .done(done_v[0]),
    .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  add_sub_seq #(.WIDTH(8), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .start(st_v[1]), .sub(sub),
    .a(a[7:0]), .b(b[7:0]), .busy(busy_v[1]), .done(done_v[1]),
    .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  add_sub_seq #(.WIDTH(8), .CHUNK(8)) u2 (
    .clk(clk), .rst(rst), .start(st_v[2]), .sub(sub),
    .a(a[7:0]), .b(b[7:0]), .busy(busy_v[2]), .done(done_v[2]),
    .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  add_sub_seq #(.WIDTH(32), .CHUNK(8)) u3 (
    .clk(clk), .rst(rst), .start(st_v[3]), .sub(sub),
    .a(a), .b(b), .busy(busy_v[3]), .done(done_v[3]),
    .s(s3), .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]));

  function automatic int nch(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] es,
                              input logic ec, input logic eo,
                              input logic ez);
    exp_t r;
    r.id  = 0;
    r.s   = es;
    r.c   = ec;
    r.o   = eo;
    r.z   = ez;
    r.due = 0;
    return r;
  endfunction

  // plain integer reference for a +/- b at 8 or 32 bits
  function automatic exp_t model(input int id, input logic [31:0] x,
                                 input logic [31:0] y, input logic sb);
    exp_t        r;
    int          w;
    logic [31:0] mask;
    logic [31:0] xm;
    logic [31:0] yb;
    logic [32:0] full;
    logic [31:0] res;
    w    = (id == 3) ? 32 : 8;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    xm   = x & mask;
    yb   = (sb ? ~y : y) & mask;
    full = {1'b0, xm} + {1'b0, yb} + 33'(sb);
    res  = full[31:0] & mask;
    r    = mk(res, (w == 32) ? full[32] : full[8],
              (xm[w-1] == yb[w-1]) && (res[w-1] != xm[w-1]),
              res == 32'd0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               nm, act, req, cyc);
    end
  endtask

  // drive one op starting at posedge+1; ends at posedge+1 of DONE entry
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic isub, input exp_t ie,
                       input bit keep);
    exp_t e;
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = ie;
    e.id  = sel;
    e.due = cyc + nch(sel);
    sbq.push_back(e);
    if (!keep) start = 1'b0;
    repeat (nch(sel)) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sbq.size() != 0) chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    exp_t e;
    nvec = 0;
    nfail = 0;
    for (int k = 0; k < 4; k++) busyc[k] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < 4; k++) busyc[k] = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (done_v[k]) begin
            if (sbq.size() == 0) begin
              nvec++;
              nfail++;
              $display("FAIL spurious_done: dut %0d pulsed done, none expected",
                       k);
            end else begin
              e = sbq.pop_front();
              chk("dut_id", 64'(k), 64'(e.id));
              chk("result_s", 64'(s_v[k]), 64'(e.s));
              chk("cout_ovf_zero", 64'({cout_v[k], ovf_v[k], zero_v[k]}),
                  64'({e.c, e.o, e.z}));
              chk("latency", 64'(cyc), 64'(e.due));
              chk("busy_cycles", 64'(busyc[k]), 64'(nch(k)));
            end
            busyc[k] = 0;
          end else if (busy_v[k]) begin
            busyc[k]++;
          end
        end
        if (sbq.size() != 0 && cyc > sbq[0].due + 3) begin
          nvec++;
          nfail++;
          $display("FAIL timeout: no done by cycle %0d, due %0d",
                   cyc, sbq[0].due);
          void'(sbq.pop_front());
        end
      end
    end
  end

  vec_t dv [10] = '{
    '{8'd100, 8'd27,  1'b0, 8'h7F, 1'b0, 1'b0, 1'b0},
    '{8'd100, 8'd100, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0},
    '{8'hFF,  8'h01,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h7F,  8'h01,  1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
    '{8'd5,   8'd7,   1'b1, 8'hFE, 1'b0, 1'b0, 1'b0},
    '{8'd7,   8'd5,   1'b1, 8'h02, 1'b1, 1'b0, 1'b0},
    '{8'h80,  8'h01,  1'b1, 8'h7F, 1'b1, 1'b1, 1'b0},
    '{8'd5,   8'd5,   1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h33,  8'h00,  1'b1, 8'h33, 1'b1, 1'b0, 1'b0},
    '{8'h00,  8'h80,  1'b1, 8'h80, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    exp_t        e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    sel   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_s0", 64'(s_v[0]), 64'd0);
    chk("reset_s3", 64'(s_v[3]), 64'd0);
    chk("reset_flags",
        64'({busy_v, done_v, cout_v, ovf_v, zero_v}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      issue({24'b0, dv[i].a}, {24'b0, dv[i].b}, dv[i].sub,
            mk({24'b0, dv[i].s}, dv[i].c, dv[i].o, dv[i].z), 1'b0);
    drain();

    // start held high: back-to-back accepts in DONE
    issue(32'h10, 32'h20, 1'b0, mk(32'h30, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'hF0, 32'h10, 1'b1, mk(32'hE0, 1'b1, 1'b0, 1'b0), 1'b1);
    issue(32'h7F, 32'hFF, 1'b1, mk(32'h80, 1'b0, 1'b1, 1'b0), 1'b0);
    drain();

    // start pulse and operand churn while running
    a     = 32'h3C;
    b     = 32'h41;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = mk(32'h7D, 1'b0, 1'b0, 1'b0);
    e.id  = 0;
    e.due = cyc + 2;
    sbq.push_back(e);
    a     = 32'hFF;
    b     = 32'hFF;
    sub   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 32'h00;
    repeat (4) @(posedge clk);
    #1;
    drain();

    // abort mid-run on the edge that would process chunk 1
    a     = 32'h12;
    b     = 32'h34;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_s", 64'(s_v[0]), 64'd0);
    chk("abort_flags", 64'({busy_v[0], done_v[0], cout_v[0],
                            ovf_v[0], zero_v[0]}), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(32'h12, 32'h34, 1'b0, mk(32'h46, 1'b0, 1'b0, 1'b0), 1'b0);
    drain();

    for (int k = 1; k < 4; k++) begin
      sel = k;
      @(posedge clk);
      #1;
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom;
        rb = $urandom;
        if (k != 3) begin
          ra = ra & 32'hFF;
          rb = rb & 32'hFF;
        end
        rs = 1'($urandom_range(0, 1));
        issue(ra, rb, rs, model(k, ra, rb, rs), 1'b0);
      end
      drain();
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
